// File: rtl/spectrum_frame_buffer_pkg.sv
// Shared defaults, per-channel state encoding and peak-search range for the
// spectrum frame buffer.
package spectrum_frame_buffer_pkg;

    localparam int unsigned FRAME_POINTS_DEF = 8192;
    localparam int unsigned ADDR_WIDTH_DEF   = 13;
    localparam int unsigned DATA_WIDTH_DEF   = 16;

    // DC bin is excluded from the peak search; the upper half is excluded too
    localparam int unsigned PEAK_LO_BIN = 1;

    typedef enum logic [1:0] {
        CH_SYNC,
        CH_FILL,
        CH_PEND
    } ch_state_t;

    function automatic int unsigned peak_hi_bin(input int unsigned points);
        return points / 2 - 1;
    endfunction

endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks of one channel:
// one write port, one registered read port.
module spectrum_bank_ram #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_frame_tracker.sv
// Per-channel frame assembly: bin sequence tracking, ping-pong bank swap
// gated by the reader lock, and running peak search over the lower half.
module spectrum_frame_tracker
    import spectrum_frame_buffer_pkg::*;
#(
    parameter int unsigned FRAME_POINTS = FRAME_POINTS_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  valid,
    input  logic                  lock,
    output logic                  wr_en,
    output logic [ADDR_WIDTH:0]   wr_addr,
    output logic                  disp_bank,
    output logic                  frame_ready,
    output logic                  disp_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [DATA_WIDTH-1:0] peak_mag,
    output logic [ADDR_WIDTH-1:0] peak_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FRAME_POINTS - 1);
    localparam logic [ADDR_WIDTH-1:0] PEAK_LO  = ADDR_WIDTH'(PEAK_LO_BIN);
    localparam logic [ADDR_WIDTH-1:0] PEAK_HI  = ADDR_WIDTH'(peak_hi_bin(FRAME_POINTS));

    ch_state_t             state;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] exp_cnt;
    logic [DATA_WIDTH-1:0] run_mag;
    logic [ADDR_WIDTH-1:0] run_addr;

    logic in_order;
    logic at_start;
    logic in_peak;
    logic swap;

    always_comb begin
        in_order = valid && (state == CH_FILL) && (addr == exp_cnt);
        // exp_cnt is never 0 in FILL, so a bin-0 write there is always a restart
        at_start = valid && (addr == '0) && (state != CH_PEND);
        in_peak  = (addr >= PEAK_LO) && (addr <= PEAK_HI);
        swap     = !lock && ((in_order && (addr == LAST_BIN)) || (state == CH_PEND));
        wr_en    = in_order || at_start;
        wr_addr  = {wr_bank, addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CH_SYNC;
            wr_bank     <= 1'b0;
            disp_bank   <= 1'b1;
            exp_cnt     <= '0;
            run_mag     <= '0;
            run_addr    <= '0;
            frame_ready <= 1'b0;
            disp_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            peak_mag    <= '0;
            peak_addr   <= '0;
        end else begin
            frame_ready <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                CH_SYNC: begin
                    if (at_start) begin
                        exp_cnt  <= ADDR_WIDTH'(1);
                        run_mag  <= '0;
                        run_addr <= '0;
                        state    <= CH_FILL;
                    end
                end
                CH_FILL: begin
                    if (in_order) begin
                        exp_cnt <= exp_cnt + 1'b1;
                        if (in_peak && (data > run_mag)) begin
                            run_mag  <= data;
                            run_addr <= addr;
                        end
                        if (addr == LAST_BIN) begin
                            exp_cnt <= '0;
                            state   <= lock ? CH_PEND : CH_SYNC;
                        end
                    end else if (at_start) begin
                        frame_err <= 1'b1;
                        exp_cnt   <= ADDR_WIDTH'(1);
                        run_mag   <= '0;
                        run_addr  <= '0;
                    end else if (valid) begin
                        frame_err <= 1'b1;
                        exp_cnt   <= '0;
                        state     <= CH_SYNC;
                    end
                end
                CH_PEND: begin
                    overrun <= valid;
                    if (!lock) begin
                        state <= CH_SYNC;
                    end
                end
                default: state <= CH_SYNC;
            endcase

            // The last bin is outside the peak range, so run_* is final here
            if (swap) begin
                disp_bank   <= wr_bank;
                wr_bank     <= ~wr_bank;
                peak_mag    <= run_mag;
                peak_addr   <= run_addr;
                frame_ready <= 1'b1;
                disp_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spectrum_frame_buffer.sv
// Dual-channel spectrum frame buffer: per-channel frame trackers and
// ping-pong bank RAMs behind a shared registered read port.
module spectrum_frame_buffer
    import spectrum_frame_buffer_pkg::*;
#(
    parameter int unsigned FRAME_POINTS = FRAME_POINTS_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ch1_spectrum_data,
    input  logic [ADDR_WIDTH-1:0] ch1_spectrum_addr,
    input  logic                  ch1_spectrum_valid,
    input  logic [DATA_WIDTH-1:0] ch2_spectrum_data,
    input  logic [ADDR_WIDTH-1:0] ch2_spectrum_addr,
    input  logic                  ch2_spectrum_valid,
    input  logic                  ch1_rd_lock,
    input  logic                  ch2_rd_lock,
    input  logic                  rd_en,
    input  logic                  rd_ch,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  ch1_frame_ready,
    output logic                  ch2_frame_ready,
    output logic                  ch1_disp_valid,
    output logic                  ch2_disp_valid,
    output logic                  ch1_frame_err,
    output logic                  ch2_frame_err,
    output logic                  ch1_overrun,
    output logic                  ch2_overrun,
    output logic [DATA_WIDTH-1:0] ch1_peak_mag,
    output logic [DATA_WIDTH-1:0] ch2_peak_mag,
    output logic [ADDR_WIDTH-1:0] ch1_peak_addr,
    output logic [ADDR_WIDTH-1:0] ch2_peak_addr
);

    logic [1:0]            wr_en;
    logic [1:0]            disp_bank;
    logic [ADDR_WIDTH:0]   wr_addr [2];
    logic [DATA_WIDTH-1:0] ram_q   [2];
    logic                  rd_sel;

    spectrum_frame_tracker #(
        .FRAME_POINTS (FRAME_POINTS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_trk1 (
        .clk         (clk),
        .rst         (rst),
        .data        (ch1_spectrum_data),
        .addr        (ch1_spectrum_addr),
        .valid       (ch1_spectrum_valid),
        .lock        (ch1_rd_lock),
        .wr_en       (wr_en[0]),
        .wr_addr     (wr_addr[0]),
        .disp_bank   (disp_bank[0]),
        .frame_ready (ch1_frame_ready),
        .disp_valid  (ch1_disp_valid),
        .frame_err   (ch1_frame_err),
        .overrun     (ch1_overrun),
        .peak_mag    (ch1_peak_mag),
        .peak_addr   (ch1_peak_addr)
    );

    spectrum_frame_tracker #(
        .FRAME_POINTS (FRAME_POINTS),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_trk2 (
        .clk         (clk),
        .rst         (rst),
        .data        (ch2_spectrum_data),
        .addr        (ch2_spectrum_addr),
        .valid       (ch2_spectrum_valid),
        .lock        (ch2_rd_lock),
        .wr_en       (wr_en[1]),
        .wr_addr     (wr_addr[1]),
        .disp_bank   (disp_bank[1]),
        .frame_ready (ch2_frame_ready),
        .disp_valid  (ch2_disp_valid),
        .frame_err   (ch2_frame_err),
        .overrun     (ch2_overrun),
        .peak_mag    (ch2_peak_mag),
        .peak_addr   (ch2_peak_addr)
    );

    // Reads use the display bank as registered now, i.e. pre-swap on a swap cycle
    spectrum_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram1 (
        .clk     (clk),
        .wr_en   (wr_en[0]),
        .wr_addr (wr_addr[0]),
        .wr_data (ch1_spectrum_data),
        .rd_en   (rd_en && !rd_ch),
        .rd_addr ({disp_bank[0], rd_addr}),
        .rd_data (ram_q[0])
    );

    spectrum_bank_ram #(
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram2 (
        .clk     (clk),
        .wr_en   (wr_en[1]),
        .wr_addr (wr_addr[1]),
        .wr_data (ch2_spectrum_data),
        .rd_en   (rd_en && rd_ch),
        .rd_addr ({disp_bank[1], rd_addr}),
        .rd_data (ram_q[1])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_sel <= rd_ch;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            rd_data = rd_sel ? ram_q[1] : ram_q[0];
        end
    end

endmodule
